// File: rtl/mac_hash_table.sv
// Direct-mapped MAC table: lookups return the learned port, learns insert or update.
// Key/port live in a synchronous-read RAM; validity lives in flops so clear/reset is instant.
module mac_hash_table #(
    parameter int KEY_WIDTH  = 48,
    parameter int HASH_WIDTH = 32,
    parameter int INDEX_BITS = 8,
    parameter int PORT_WIDTH = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  lkp_valid,
    output logic                  lkp_ready,
    input  logic [KEY_WIDTH-1:0]  lkp_key,
    input  logic [HASH_WIDTH-1:0] lkp_hash,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  res_hit,
    output logic [PORT_WIDTH-1:0] res_port,
    input  logic                  lrn_valid,
    output logic                  lrn_ready,
    input  logic [KEY_WIDTH-1:0]  lrn_key,
    input  logic [HASH_WIDTH-1:0] lrn_hash,
    input  logic [PORT_WIDTH-1:0] lrn_port,
    input  logic                  clear,
    output logic [CNT_WIDTH-1:0]  hit_cnt,
    output logic [CNT_WIDTH-1:0]  miss_cnt,
    output logic [CNT_WIDTH-1:0]  evict_cnt
);

    localparam int NB = 1 << INDEX_BITS;
    localparam int DW = KEY_WIDTH + PORT_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CMP,
        S_WR,
        S_RESP
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [NB-1:0]         r_vld;
    logic [KEY_WIDTH-1:0]  r_key;
    logic [INDEX_BITS-1:0] r_idx;
    logic [PORT_WIDTH-1:0] r_port;
    logic                  r_op_lrn;
    logic [DW-1:0]         r_mem [NB];
    logic [DW-1:0]         r_rdata;
    logic                  r_res_valid;
    logic                  r_res_hit;
    logic [PORT_WIDTH-1:0] r_res_port;
    logic [CNT_WIDTH-1:0]  r_hit_cnt;
    logic [CNT_WIDTH-1:0]  r_miss_cnt;
    logic [CNT_WIDTH-1:0]  r_evict_cnt;

    logic                  w_lkp_rdy;
    logic                  w_lrn_rdy;
    logic                  w_lkp_acc;
    logic                  w_lrn_acc;
    logic [KEY_WIDTH-1:0]  w_st_key;
    logic [PORT_WIDTH-1:0] w_st_port;
    logic                  w_match;
    logic                  w_same;
    logic                  w_unused;

    assign w_lkp_rdy = resetn && (r_state == S_IDLE) && !clear;
    assign w_lrn_rdy = w_lkp_rdy && !lkp_valid;
    assign w_lkp_acc = lkp_valid && w_lkp_rdy;
    assign w_lrn_acc = lrn_valid && w_lrn_rdy;

    assign w_st_key  = r_rdata[DW-1:PORT_WIDTH];
    assign w_st_port = r_rdata[PORT_WIDTH-1:0];
    assign w_match   = r_vld[r_idx] && (w_st_key == r_key);
    assign w_same    = w_match && (w_st_port == r_port);

    // Only the low hash bits address the table.
    assign w_unused = ^{lkp_hash[HASH_WIDTH-1:INDEX_BITS],
                        lrn_hash[HASH_WIDTH-1:INDEX_BITS]};

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_lkp_acc || w_lrn_acc) w_next = S_RD;
            S_RD:   w_next = S_CMP;
            S_CMP: begin
                if (!r_op_lrn)   w_next = S_RESP;
                else if (w_same) w_next = S_IDLE;
                else             w_next = S_WR;
            end
            S_WR:   w_next = S_IDLE;
            S_RESP: if (res_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_vld       <= '0;
            r_key       <= '0;
            r_idx       <= '0;
            r_port      <= '0;
            r_op_lrn    <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_hit   <= 1'b0;
            r_res_port  <= '0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
            r_evict_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_lkp_acc) begin
                r_key    <= lkp_key;
                r_idx    <= lkp_hash[INDEX_BITS-1:0];
                r_op_lrn <= 1'b0;
            end else if (w_lrn_acc) begin
                r_key    <= lrn_key;
                r_idx    <= lrn_hash[INDEX_BITS-1:0];
                r_port   <= lrn_port;
                r_op_lrn <= 1'b1;
            end
            if (r_state == S_CMP) begin
                if (!r_op_lrn) begin
                    r_res_valid <= 1'b1;
                    r_res_hit   <= w_match;
                    r_res_port  <= w_match ? w_st_port : '0;
                    if (w_match) r_hit_cnt  <= r_hit_cnt + CNT_WIDTH'(1);
                    else         r_miss_cnt <= r_miss_cnt + CNT_WIDTH'(1);
                end else if (r_vld[r_idx] && !w_match) begin
                    r_evict_cnt <= r_evict_cnt + CNT_WIDTH'(1);
                end
            end
            if (r_state == S_RESP && res_ready) r_res_valid <= 1'b0;
            // A write in flight re-sets its own bit even during a clear.
            if (clear) r_vld <= '0;
            if (r_state == S_WR) r_vld[r_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_WR) r_mem[r_idx] <= {r_key, r_port};
        r_rdata <= r_mem[r_idx];
    end

    assign lkp_ready = w_lkp_rdy;
    assign lrn_ready = w_lrn_rdy;
    assign res_valid = r_res_valid;
    assign res_hit   = r_res_hit;
    assign res_port  = r_res_port;
    assign hit_cnt   = r_hit_cnt;
    assign miss_cnt  = r_miss_cnt;
    assign evict_cnt = r_evict_cnt;

endmodule

// File: tb/tb_mac_hash_table.sv
// Directed bench for mac_hash_table: lookups, learns, evictions,
// lookup/learn conflict, result back-pressure, clear and mid-flight reset.
module tb_mac_hash_table;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        lkp_valid = 1'b0;
    logic        lkp_ready;
    logic [47:0] lkp_key = '0;
    logic [31:0] lkp_hash = '0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic        res_hit;
    logic [7:0]  res_port;
    logic        lrn_valid = 1'b0;
    logic        lrn_ready;
    logic [47:0] lrn_key = '0;
    logic [31:0] lrn_hash = '0;
    logic [7:0]  lrn_port = '0;
    logic        clear = 1'b0;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
    logic [31:0] evict_cnt;

    int checks = 0;
    int errors = 0;
    int exp_hit = 0;
    int exp_miss = 0;
    int exp_evict = 0;

    always #5 clk = ~clk;

    mac_hash_table dut (
        .clk(clk), .resetn(resetn),
        .lkp_valid(lkp_valid), .lkp_ready(lkp_ready),
        .lkp_key(lkp_key), .lkp_hash(lkp_hash),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_hit(res_hit), .res_port(res_port),
        .lrn_valid(lrn_valid), .lrn_ready(lrn_ready),
        .lrn_key(lrn_key), .lrn_hash(lrn_hash), .lrn_port(lrn_port),
        .clear(clear),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .evict_cnt(evict_cnt)
    );

    // lat = negedges after the accept edge until res_valid is seen (3 == edge T+2)
    task automatic do_lookup(input logic [47:0] key, input logic [31:0] hash,
                             output logic hit, output logic [7:0] port,
                             output int lat);
        int n;
        @(negedge clk);
        lkp_key = key; lkp_hash = hash; lkp_valid = 1'b1;
        n = 0;
        while (!lkp_ready && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (lkp_ready !== 1'b1) begin
            errors++;
            $display("FAIL lkp_accept_timeout: ready=%b required 1", lkp_ready);
        end
        @(posedge clk); #1 lkp_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!res_valid && lat < 20);
        hit = res_hit; port = res_port;
    endtask

    // busy = cycles lrn_ready stays low after the accept edge
    task automatic do_learn(input logic [47:0] key, input logic [31:0] hash,
                            input logic [7:0] port, output int busy);
        int n;
        @(negedge clk);
        lrn_key = key; lrn_hash = hash; lrn_port = port; lrn_valid = 1'b1;
        n = 0;
        while (!lrn_ready && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (lrn_ready !== 1'b1) begin
            errors++;
            $display("FAIL lrn_accept_timeout: ready=%b required 1", lrn_ready);
        end
        @(posedge clk); #1 lrn_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!lrn_ready && n < 20);
        busy = n - 1;
    endtask

    task automatic test_counters(input string tag);
        checks++;
        if (hit_cnt !== 32'(exp_hit) || miss_cnt !== 32'(exp_miss)
            || evict_cnt !== 32'(exp_evict)) begin
            errors++;
            $display("FAIL cnt_%s: hit/miss/evict=%0d/%0d/%0d required %0d/%0d/%0d",
                     tag, hit_cnt, miss_cnt, evict_cnt, exp_hit, exp_miss, exp_evict);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || res_hit !== 1'b0 || res_port !== 8'h00
            || lkp_ready !== 1'b0 || lrn_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rv=%b rh=%b rp=%h lkr=%b lrr=%b required 0",
                     res_valid, res_hit, res_port, lkp_ready, lrn_ready);
        end
        test_counters("reset");
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (lkp_ready !== 1'b1 || lrn_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: lkr=%b lrr=%b required 1 1",
                     lkp_ready, lrn_ready);
        end
    endtask

    task automatic test_lookup_miss();
        logic h; logic [7:0] p; int lat;
        do_lookup(48'h001122334455, 32'h00000005, h, p, lat);
        exp_miss++;
        checks++;
        if (lat !== 3 || h !== 1'b0 || p !== 8'h00) begin
            errors++;
            $display("FAIL first_miss: lat=%0d hit=%b port=%h required 3 0 00", lat, h, p);
        end
        @(negedge clk);
        test_counters("first_miss");
    endtask

    task automatic test_learn_hit();
        logic h; logic [7:0] p; int lat; int busy;
        do_learn(48'h001122334455, 32'h00000005, 8'h04, busy);
        checks++;
        if (busy !== 3) begin
            errors++;
            $display("FAIL learn_busy_update: busy=%0d required 3", busy);
        end
        do_lookup(48'h001122334455, 32'h00000005, h, p, lat);
        exp_hit++;
        checks++;
        if (lat !== 3 || h !== 1'b1 || p !== 8'h04) begin
            errors++;
            $display("FAIL learned_hit: lat=%0d hit=%b port=%h required 3 1 04", lat, h, p);
        end
        do_learn(48'h001122334455, 32'h00000005, 8'h04, busy);
        checks++;
        if (busy !== 2) begin
            errors++;
            $display("FAIL learn_busy_nochange: busy=%0d required 2", busy);
        end
        test_counters("learn_hit");
    endtask

    task automatic test_evict();
        logic h; logic [7:0] p; int lat; int busy;
        do_learn(48'hAABBCCDDEEFF, 32'hFFFF0005, 8'h10, busy);
        exp_evict++;
        test_counters("evict");
        do_lookup(48'h001122334455, 32'h00000005, h, p, lat);
        exp_miss++;
        checks++;
        if (h !== 1'b0 || p !== 8'h00) begin
            errors++;
            $display("FAIL evicted_miss: hit=%b port=%h required 0 00", h, p);
        end
        do_lookup(48'hAABBCCDDEEFF, 32'hFFFF0005, h, p, lat);
        exp_hit++;
        checks++;
        if (h !== 1'b1 || p !== 8'h10) begin
            errors++;
            $display("FAIL new_key_hit: hit=%b port=%h required 1 10", h, p);
        end
        @(negedge clk);
        test_counters("after_evict");
    endtask

    task automatic test_conflict();
        logic h; logic [7:0] p; int lat; int n;
        n = 0;
        while (!lkp_ready && n < 20) begin @(negedge clk); n++; end
        lkp_key = 48'hAABBCCDDEEFF; lkp_hash = 32'hFFFF0005; lkp_valid = 1'b1;
        lrn_key = 48'hAABBCCDDEEFF; lrn_hash = 32'h00000105;
        lrn_port = 8'h20; lrn_valid = 1'b1;
        #1;
        checks++;
        if (lkp_ready !== 1'b1 || lrn_ready !== 1'b0) begin
            errors++;
            $display("FAIL conflict_ready: lkr=%b lrr=%b required 1 0", lkp_ready, lrn_ready);
        end
        @(posedge clk); #1 lkp_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!res_valid && lat < 20);
        exp_hit++;
        checks++;
        if (lat !== 3 || res_hit !== 1'b1 || res_port !== 8'h10) begin
            errors++;
            $display("FAIL conflict_old_data: lat=%0d hit=%b port=%h required 3 1 10",
                     lat, res_hit, res_port);
        end
        n = 0;
        while (!lrn_ready && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (lrn_ready !== 1'b1) begin
            errors++;
            $display("FAIL conflict_learn_timeout: lrr=%b required 1", lrn_ready);
        end
        @(posedge clk); #1 lrn_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!lrn_ready && n < 20);
        do_lookup(48'hAABBCCDDEEFF, 32'hFFFF0005, h, p, lat);
        exp_hit++;
        checks++;
        if (h !== 1'b1 || p !== 8'h20) begin
            errors++;
            $display("FAIL conflict_new_data: hit=%b port=%h required 1 20", h, p);
        end
        @(negedge clk);
        test_counters("conflict");
    endtask

    task automatic test_backpressure();
        logic h; logic [7:0] p; int lat; int bad;
        res_ready = 1'b0;
        do_lookup(48'hAABBCCDDEEFF, 32'hFFFF0005, h, p, lat);
        exp_hit++;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (res_valid !== 1'b1 || res_hit !== 1'b1 || res_port !== 8'h20
                || lkp_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL stall_hold: %0d unstable cycles required 0", bad);
        end
        res_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || lkp_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: rv=%b lkr=%b required 0 1", res_valid, lkp_ready);
        end
        test_counters("stall");
    endtask

    task automatic test_clear();
        logic h; logic [7:0] p; int lat; int busy; int hits;
        for (int i = 1; i <= 3; i++)
            do_learn(48'h0200000000 + 48'(i), 32'(i), 8'(1 << i), busy);
        @(negedge clk);
        clear = 1'b1;
        #1;
        checks++;
        if (lkp_ready !== 1'b0 || lrn_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_ready: lkr=%b lrr=%b required 0 0", lkp_ready, lrn_ready);
        end
        @(negedge clk);
        clear = 1'b0;
        hits = 0;
        for (int i = 1; i <= 3; i++) begin
            do_lookup(48'h0200000000 + 48'(i), 32'(i), h, p, lat);
            exp_miss++;
            if (h !== 1'b0 || p !== 8'h00) hits++;
        end
        checks++;
        if (hits !== 0) begin
            errors++;
            $display("FAIL clear_all_miss: %0d hits after clear required 0", hits);
        end
        @(negedge clk);
        test_counters("clear");
    endtask

    task automatic test_reset_mid_rd();
        logic h; logic [7:0] p; int lat; int busy; int seen;
        do_learn(48'h0A0B0C0D0E0F, 32'h00000007, 8'h01, busy);
        @(negedge clk);
        lkp_key = 48'h0A0B0C0D0E0F; lkp_hash = 32'h00000007; lkp_valid = 1'b1;
        @(posedge clk); #1 lkp_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        exp_hit = 0; exp_miss = 0; exp_evict = 0;
        #1;
        checks++;
        if (lkp_ready !== 1'b0 || lrn_ready !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_rd: lkr=%b lrr=%b rv=%b required 0 0 0",
                     lkp_ready, lrn_ready, res_valid);
        end
        test_counters("mid_reset");
        @(negedge clk);
        resetn = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL aborted_result: %0d result cycles required 0", seen);
        end
        do_lookup(48'h0A0B0C0D0E0F, 32'h00000007, h, p, lat);
        exp_miss++;
        checks++;
        if (lat !== 3 || h !== 1'b0 || p !== 8'h00) begin
            errors++;
            $display("FAIL post_reset_miss7: lat=%0d hit=%b port=%h required 3 0 00", lat, h, p);
        end
        do_lookup(48'hAABBCCDDEEFF, 32'hFFFF0005, h, p, lat);
        exp_miss++;
        checks++;
        if (h !== 1'b0 || p !== 8'h00) begin
            errors++;
            $display("FAIL post_reset_miss5: hit=%b port=%h required 0 00", h, p);
        end
        @(negedge clk);
        test_counters("post_reset");
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_lookup_miss();
        test_learn_hit();
        test_evict();
        test_conflict();
        test_backpressure();
        test_clear();
        test_reset_mid_rd();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
